// File: rtl/branch_hazard_forward_unit.sv
// ID-stage branch operand hazard unit: bypass select plus stall sequencer for branches resolved in ID.
// Optional macro BRANCH_HAZARD_STATS_EN adds saturating stall / forward-event counters.
module branch_hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int STAT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic                          id_is_branch,
  input  logic                          id_kill,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          ex_reg_write,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          mem_reg_write,
  input  logic                          mem_mem_read,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic                          wb_reg_write,
  input  logic [REG_ADDR_W-1:0]         wb_rd,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          bubble_ex,
  output logic                          busy
`ifdef BRANCH_HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]             stat_stall_cycles,
  output logic [STAT_W-1:0]             stat_fwd_events
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [1:0]              need;
  logic [1:0]              need_i;
  logic [2*NUM_SRC-1:0]    fwd_raw;
  logic [REG_ADDR_W-1:0]   src;
  logic                    e_hit, m_hit, w_hit;
  logic                    stall_fsm;

  always_comb begin
    need    = 2'd0;
    fwd_raw = '0;
    src     = '0;
    e_hit   = 1'b0;
    m_hit   = 1'b0;
    w_hit   = 1'b0;
    need_i  = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src   = id_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      e_hit = id_src_used[i] && ex_reg_write  && (ex_rd  != '0) && (ex_rd  == src);
      m_hit = id_src_used[i] && mem_reg_write && (mem_rd != '0) && (mem_rd == src);
      w_hit = id_src_used[i] && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);
      if (e_hit && ex_mem_read)       need_i = 2'd2;
      else if (e_hit)                 need_i = 2'd1;
      else if (m_hit && mem_mem_read) need_i = 2'd1;
      else                            need_i = 2'd0;
      if (need_i > need) need = need_i;
      // Most recent producer wins: a MEM ALU result shadows an older WB value.
      if (m_hit && !mem_mem_read) fwd_raw[2*i +: 2] = 2'b10;
      else if (w_hit)             fwd_raw[2*i +: 2] = 2'b01;
      else                        fwd_raw[2*i +: 2] = 2'b00;
    end
    if (!(id_valid && id_is_branch && !id_kill)) need = 2'd0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_fsm = 1'b0;
    if (id_kill) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else if (state_q == STALL && cnt_q != 2'd0) begin
      stall_fsm = 1'b1;
      cnt_d     = cnt_q - 2'd1;
    end else if (need != 2'd0) begin
      // Re-evaluation also happens at the end of a stall run, so a residual hazard reloads here.
      stall_fsm = 1'b1;
      state_d   = STALL;
      cnt_d     = need - 2'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
  end

  assign stall     = stall_fsm & rst_n;
  assign bubble_ex = stall;
  assign busy      = (state_q == STALL);
  assign fwd_sel   = (stall || !id_is_branch) ? '0 : fwd_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
  logic [STAT_W-1:0] stat_fwd_q, stat_fwd_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_fwd_d   = stat_fwd_q;
    if (stall && stat_stall_q != '1) stat_stall_d = stat_stall_q + 1'b1;
    if (!stall && id_is_branch && (fwd_sel != '0) && stat_fwd_q != '1)
      stat_fwd_d = stat_fwd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q   <= stat_fwd_d;
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_fwd_events   = stat_fwd_q;
`endif

endmodule

// File: tb/tb_branch_hazard_forward_unit.sv
// Self-checking bench for branch_hazard_forward_unit: directed plan scenarios plus randomized run against a cycle model.
module tb_branch_hazard_forward_unit;
  localparam int W = 5;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid, id_is_branch, id_kill;
  logic [N*W-1:0] id_src_addr;
  logic [N-1:0]   id_src_used;
  logic           ex_reg_write, ex_mem_read;
  logic [W-1:0]   ex_rd;
  logic           mem_reg_write, mem_mem_read;
  logic [W-1:0]   mem_rd;
  logic           wb_reg_write;
  logic [W-1:0]   wb_rd;
  logic [2*N-1:0] fwd_sel;
  logic           stall, bubble_ex, busy;
`ifdef BRANCH_HAZARD_STATS_EN
  logic [15:0]    stat_stall_cycles, stat_fwd_events;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_hazard_forward_unit #(.REG_ADDR_W(W), .NUM_SRC(N), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_kill(id_kill),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .fwd_sel(fwd_sel), .stall(stall), .bubble_ex(bubble_ex), .busy(busy)
`ifdef BRANCH_HAZARD_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_fwd_events(stat_fwd_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_valid = 1'b0; id_is_branch = 1'b0; id_kill = 1'b0;
    id_src_addr = '0; id_src_used = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
    wb_reg_write = 1'b0; wb_rd = '0;
  endtask

  task automatic branch_on(input int rs, input int rt, input logic [1:0] used);
    id_valid = 1'b1; id_is_branch = 1'b1; id_kill = 1'b0;
    id_src_addr = {rt[W-1:0], rs[W-1:0]};
    id_src_used = used;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    branch_on(7, 0, 2'b01);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || bubble_ex !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b bubble=%b busy=%b, required 0/0/0", stall, bubble_ex, busy);
    end
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fwd_mem_wb();
    clear_inputs();
    branch_on(3, 4, 2'b11);
    mem_reg_write = 1'b1; mem_rd = 5'd3;
    wb_reg_write = 1'b1;  wb_rd = 5'd4;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0110) begin
      n_err++;
      $display("FAIL fwd_mem_wb: stall=%b fwd=%b, required 0 0110", stall, fwd_sel);
    end
    // Same register in MEM and WB: MEM wins.
    wb_rd = 5'd3;
    @(negedge clk);
    n_cmp++;
    if (fwd_sel !== 4'b0010) begin
      n_err++;
      $display("FAIL fwd_mem_over_wb: fwd=%b, required 0010", fwd_sel);
    end
    next_cycle();
  endtask

  task automatic test_alu_in_ex();
    clear_inputs();
    branch_on(5, 0, 2'b01);
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || bubble_ex !== 1'b1 || busy !== 1'b0 || fwd_sel !== 4'b0000) begin
      n_err++;
      $display("FAIL alu_ex_c0: stall=%b bubble=%b busy=%b fwd=%b, required 1 1 0 0000", stall, bubble_ex, busy, fwd_sel);
    end
    next_cycle();
    ex_reg_write = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b1; mem_rd = 5'd5;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b1 || fwd_sel !== 4'b0010) begin
      n_err++;
      $display("FAIL alu_ex_c1: stall=%b busy=%b fwd=%b, required 0 1 0010", stall, busy, fwd_sel);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL alu_ex_idle: busy=%b, required 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_load_in_ex();
    clear_inputs();
    branch_on(7, 0, 2'b01);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_c0: stall=%b busy=%b, required 1 0", stall, busy);
    end
    next_cycle();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd7;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL load_c1: stall=%b busy=%b, required 1 1", stall, busy);
    end
    next_cycle();
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = '0;
    wb_reg_write = 1'b1; wb_rd = 5'd7;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0001) begin
      n_err++;
      $display("FAIL load_c2: stall=%b fwd=%b, required 0 0001", stall, fwd_sel);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    branch_on(0, 0, 2'b11);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = '0;
    mem_reg_write = 1'b1; mem_rd = '0;
    wb_reg_write = 1'b1; wb_rd = '0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin
      n_err++;
      $display("FAIL zero_reg: stall=%b fwd=%b, required 0 0000", stall, fwd_sel);
    end
    next_cycle();
  endtask

  task automatic test_kill();
    clear_inputs();
    branch_on(7, 0, 2'b01);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
    next_cycle();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd7;
    id_kill = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL kill_cycle: stall=%b busy=%b, required 0 1", stall, busy);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL kill_next: busy=%b stall=%b, required 0 0", busy, stall);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    branch_on(6, 0, 2'b01);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6;
    next_cycle();
    #2;
    n_cmp++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_stall: stall=%b busy=%b, required 1 1", stall, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: stall=%b busy=%b, required 0 0", stall, busy);
    end
`ifdef BRANCH_HAZARD_STATS_EN
    n_cmp++;
    if (stat_stall_cycles !== 16'd0 || stat_fwd_events !== 16'd0) begin
      n_err++;
      $display("FAIL stats_reset: stall_cnt=%0d fwd_cnt=%0d, required 0 0", stat_stall_cycles, stat_fwd_events);
    end
`endif
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Reference model: stall cycles a branch operand needs, from where its producer sits.
  function automatic int model_need();
    int worst = 0;
    if (!(id_valid && id_is_branch && !id_kill)) return 0;
    for (int i = 0; i < N; i++) begin
      int a = int'(id_src_addr[i*W +: W]);
      int n = 0;
      if (!id_src_used[i] || a == 0) continue;
      if (ex_reg_write && int'(ex_rd) == a) n = ex_mem_read ? 2 : 1;
      else if (mem_reg_write && mem_mem_read && int'(mem_rd) == a) n = 1;
      if (n > worst) worst = n;
    end
    return worst;
  endfunction

  function automatic logic [2*N-1:0] model_fwd(input bit stalled);
    logic [2*N-1:0] r = '0;
    if (stalled || !id_is_branch) return r;
    for (int i = 0; i < N; i++) begin
      int a = int'(id_src_addr[i*W +: W]);
      if (!id_src_used[i] || a == 0) continue;
      if (mem_reg_write && !mem_mem_read && int'(mem_rd) == a) r[2*i +: 2] = 2'b10;
      else if (wb_reg_write && int'(wb_rd) == a) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  task automatic test_random();
    int rem = 0;
    bit mbusy = 0;
    bit exp_stall;
    int nd;
    clear_inputs();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      id_valid      = ($urandom_range(0, 9) != 0);
      id_is_branch  = ($urandom_range(0, 4) != 0);
      id_kill       = ($urandom_range(0, 9) == 0);
      id_src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src_used   = 2'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom);
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      ex_rd         = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      mem_mem_read  = ($urandom_range(0, 2) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 3));
      nd = model_need();
      if (id_kill)      exp_stall = 0;
      else if (rem > 0) exp_stall = 1;
      else              exp_stall = (nd > 0);
      @(negedge clk);
      n_cmp++;
      if (stall !== exp_stall || bubble_ex !== exp_stall || busy !== mbusy || fwd_sel !== model_fwd(exp_stall)) begin
        n_err++;
        $display("FAIL random[%0d]: stall=%b bubble=%b busy=%b fwd=%b, required %b %b %b %b",
                 c, stall, bubble_ex, busy, fwd_sel, exp_stall, exp_stall, mbusy, model_fwd(exp_stall));
      end
      @(posedge clk);
      if (id_kill) begin
        rem = 0; mbusy = 0;
      end else if (rem > 0) begin
        rem--; mbusy = 1;
      end else if (nd > 0) begin
        rem = nd - 1; mbusy = 1;
      end else begin
        mbusy = 0;
      end
      #1;
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    test_reset();
    test_fwd_mem_wb();
    test_alu_in_ex();
    test_load_in_ex();
    test_zero_reg();
    test_kill();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_hazard_forward_unit.md
Name: branch_hazard_forward_unit

Overview:
- Parametrised successor to the ID-stage branch forwarding logic of the 5-stage MIPS pipeline.
- Resolves operand hazards for branches compared in ID:
  - selects bypass sources (MEM or WB) for NUM_SRC operands;
  - inserts stall cycles when the producer is still in EX, or is a load in EX or MEM.
- A stall-sequencing FSM holds IF/ID and bubbles ID/EX for the exact number of required cycles.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, branch source operands checked; operand i uses slice [i*REG_ADDR_W +: REG_ADDR_W].
- STAT_W, 16, width of the optional statistics counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_is_branch  input  1  ID instruction compares operands in ID (beq/bne/jr).
- id_kill  input  1  ID instruction squashed this cycle.
- id_src_addr  input  NUM_SRC*REG_ADDR_W  source register addresses.
- id_src_used  input  NUM_SRC  per-operand "operand is read" enable.
- ex_reg_write, ex_mem_read  input  1 each  ID/EX control.
- ex_rd  input  REG_ADDR_W  EX destination.
- mem_reg_write, mem_mem_read  input  1 each  EX/MEM control.
- mem_rd  input  REG_ADDR_W  MEM destination.
- wb_reg_write  input  1  MEM/WB control.
- wb_rd  input  REG_ADDR_W  WB destination.
- fwd_sel  output  2*NUM_SRC  per-operand mux select: 00 regfile, 01 WB, 10 MEM.
- stall  output  1  hold PC and IF/ID.
- bubble_ex  output  1  zero ID/EX control; always equal to stall.
- busy  output  1  FSM in STALL state.

Behaviour:
- Match conditions, per operand i, valid only if id_src_used[i] and the producer rd != 0:
  - E_i: ex_reg_write & ex_rd match.
  - M_i: mem_reg_write & mem_rd match.
  - W_i: wb_reg_write & wb_rd match.
- Required stall cycles per operand: need_i = 2 if E_i & ex_mem_read; else 1 if E_i; else 1 if M_i & mem_mem_read; else 0.
- Overall need = max over operands; evaluated only when id_valid & id_is_branch & !id_kill, otherwise 0.
- Forwarding: fwd_sel_i = 10 if M_i & !mem_mem_read; else 01 if W_i; else 00.
  - Priority: the most recent producer wins.
  - Forced to 00 for all operands while stall = 1, and when id_is_branch = 0.
- FSM states IDLE and STALL, with a 2-bit counter cnt.
  - IDLE: stall = (need != 0), combinational, same cycle. If need != 0, next state STALL with cnt <= need - 1.
  - STALL, cnt != 0: stall = 1, cnt decrements, stay in STALL.
  - STALL, cnt == 0: re-evaluate exactly as in IDLE. A residual hazard reloads cnt and keeps STALL; otherwise go to IDLE, stall = 0, fwd_sel valid.
- Latency: ALU→branch costs 1 stall, load→branch costs 2, load in MEM costs 1; zero-stall cases forward in the same cycle.
- id_kill in any state: stall = 0 that cycle, next state IDLE, cnt = 0.
- rd = 0 never matches, so no stall and no forward for $zero.
- Simultaneous M and W match on the same operand: MEM wins (10).
- Different operands hitting different hazards: take the max stall; each operand gets its own fwd_sel.
- Reset (asynchronous, any time, including mid-stall): state IDLE, cnt 0, stat counters 0.
- Outputs during reset: stall, bubble_ex and busy are 0; fwd_sel is combinational on inputs and 00 whenever id_is_branch = 0.

Optional Feature:
- Macro: BRANCH_HAZARD_STATS_EN.
- Defined:
  - adds outputs stat_stall_cycles [STAT_W] (counts cycles with stall = 1) and stat_fwd_events [STAT_W] (counts non-stalled branch cycles with any fwd_sel != 00);
  - both saturate at all-ones and are cleared by rst_n.
- Undefined: no such ports and no counter logic.

Test Plan:
- Branch rs=3, rt=4; MEM rd=3 ALU; WB rd=4 → stall 0, fwd_sel = {01,10} (rt,rs).
- Branch rs=5; EX rd=5 ALU → stall 1 for 1 cycle, then (producer in MEM) fwd_sel rs = 10, stall 0.
- Branch rs=7; EX rd=7 load → stall 2 cycles, busy 1 in the second cycle, then fwd_sel rs = 01 from WB.
- Branch rs=0; EX rd=0 load with reg_write → no stall, fwd_sel 00.
- Load-use stall active (cnt = 1), id_kill pulsed → stall 0 that cycle, FSM IDLE next cycle.
- rst_n dropped mid-STALL without a clock edge → stall and busy go to 0 immediately; stats read 0 when BRANCH_HAZARD_STATS_EN is defined.
